regfile: RTL
============

# regfile

General-purpose register file for the five-stage pipeline. It answers the decode stage's two register read requests (enable plus 5-bit address) in the same cycle. It accepts one write per cycle from write-back and forwards a same-cycle write to either read port, so decode sees the newest value without a stall. Register 0 is hard-wired to zero.

## Interface
Parameters:
- DATA_W, 32, register width (matches `RegBus)
- ADDR_W, 5, register address width (matches `RegAddrBus)
- NUM_REGS, 32, number of architectural registers (2**ADDR_W)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- we  input  1  write enable from write-back (`WriteEnable = 1)
- waddr  input  ADDR_W  destination register
- wdata  input  DATA_W  write data
- re1  input  1  read enable, port 1 (from decode reg1_read_o)
- raddr1  input  ADDR_W  read address, port 1 (decode reg1_addr_o)
- rdata1  output  DATA_W  read data, port 1 (to decode reg1_data_i)
- re2  input  1  read enable, port 2 (decode reg2_read_o)
- raddr2  input  ADDR_W  read address, port 2 (decode reg2_addr_o)
- rdata2  output  DATA_W  read data, port 2 (to decode reg2_data_i)

## Operation
- Storage: NUM_REGS x DATA_W flops.
- Write path, sequential, at posedge clk:
  - rst=1: every register is cleared to 0.
  - rst=0, we=1, waddr!=0: regs[waddr] <= wdata.
  - waddr=0 is ignored, so reg 0 always stays 0.
- Read ports are combinational and identical in behaviour. Port n uses the first matching rule:
  1. rst=1 -> rdata=0
  2. raddr=0 -> rdata=0, even if a write to 0 is in flight
  3. re=0 -> rdata=0
  4. we=1 and waddr==raddr -> rdata=wdata (write-read bypass)
  5. otherwise -> rdata=regs[raddr]
- Both ports may read the same address. Both may bypass from the same write in the same cycle.
- Read data is not registered. Decode consumes it in the same cycle it issues the address.

## Timing
- Write latency: visible in the storage array from the cycle after the posedge that captures it. Visible on a read port in the same cycle through the bypass.
- Read latency: 0 cycles, combinational from raddr/re/we/waddr/wdata.
- Reset:
  - rdata1 and rdata2 are 0 while rst=1.
  - All registers read 0 from the first cycle after rst deasserts, until written.
  - A write presented while rst=1 is discarded. The bypass does not apply under reset.
  - Reset asserted mid-program clears all state on the next posedge. No partial clear.
- No handshake or back-pressure: every write is accepted and every enabled read is answered in the same cycle.
- Timing path: waddr/raddr compare plus the DATA_W 2:1 bypass mux follow the 32:1 read mux. This path must close within decode's cycle budget.

## Test plan
- Reset clear: write 0xDEADBEEF to r5, then assert rst for 1 cycle, deassert, read r5 on port 1 with re1=1 -> rdata1=0x00000000. During rst, rdata1=rdata2=0 for any address.
- Basic write/read: write 0x12345678 to r7, next cycle read r7 on both ports -> rdata1=rdata2=0x12345678. Read r8 (never written) -> 0.
- Bypass: in one cycle, we=1, waddr=3, wdata=0xA5A5A5A5, raddr1=3, raddr2=3, re1=re2=1 -> both ports return 0xA5A5A5A5 that cycle. Next cycle, with we=0, both still return 0xA5A5A5A5.
- Register zero: we=1, waddr=0, wdata=0xFFFFFFFF with raddr1=0, re1=1 -> rdata1=0 that cycle and every later cycle.
- Read enable gating: r9 holds 0x55AA55AA. With re2=0, raddr2=9 -> rdata2=0. With re2=0 and a same-cycle write to r9 -> rdata2=0.
- Back-to-back writes: write r4=1, r4=2, r4=3 on consecutive cycles while reading r4 every cycle -> rdata1 sequence 1,2,3, then 3 steady after we drops.

Source files
------------

// File: rtl/regfile_if.sv
// rtl/regfile_if.sv - write-back write port and decode read ports of the register file
interface regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;

  modport master (
    output we, waddr, wdata,
    output re1, raddr1, input rdata1,
    output re2, raddr2, input rdata2
  );

  modport slave (
    input  we, waddr, wdata,
    input  re1, raddr1, output rdata1,
    input  re2, raddr2, output rdata2
  );
endinterface

// File: rtl/regfile.sv
// rtl/regfile.sv - two-read one-write register file with write-read bypass, r0 fixed at zero
module regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 2 ** ADDR_W
) (
  input logic       clk,
  input logic       rst,
  regfile_if.slave  bus
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] stored1;
  logic [DATA_W-1:0] stored2;

  // r0 is never targeted by the write path, so it only ever holds its reset value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.we && (bus.waddr != '0)) begin
      regs[bus.waddr] <= bus.wdata;
    end
  end

  assign stored1 = regs[bus.raddr1];
  assign stored2 = regs[bus.raddr2];

  // Rule order matters: reset, then r0, then enable, then bypass, then storage.
  function automatic logic [DATA_W-1:0] read_port(
    input logic              rst_i,
    input logic              re,
    input logic [ADDR_W-1:0] raddr,
    input logic              we,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] value;
    value = '0;
    if (rst_i || (raddr == '0) || !re) begin
      value = '0;
    end else if (we && (waddr == raddr)) begin
      value = wdata;
    end else begin
      value = stored;
    end
    return value;
  endfunction

  always_comb begin
    bus.rdata1 = read_port(rst, bus.re1, bus.raddr1, bus.we, bus.waddr, bus.wdata, stored1);
  end

  always_comb begin
    bus.rdata2 = read_port(rst, bus.re2, bus.raddr2, bus.we, bus.waddr, bus.wdata, stored2);
  end

endmodule
